// File: rtl/vga_timing_gen.sv
// VGA timing master: scan counters, registered sync/blank, and colour pins masked by blank.
// Latency: the pins follow (x,y) by one pixel tick. No backpressure; the generator runs freely.
module vga_timing_gen #(
   parameter int DIV     = 2,
   parameter int HACTIVE = 640,
   parameter int HFP     = 16,
   parameter int HSYNC   = 96,
   parameter int HBP     = 48,
   parameter int VACTIVE = 480,
   parameter int VFP     = 10,
   parameter int VSYNC   = 2,
   parameter int VBP     = 33
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] x,
   output logic [9:0] y,
   input  logic [7:0] r_in,
   input  logic [7:0] g_in,
   input  logic [7:0] b_in,
   output logic       pix_en,
   output logic       vga_hsync_n,
   output logic       vga_vsync_n,
   output logic       vga_blank_n,
   output logic       vga_sync_n,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b,
   output logic       frame_start
);

   localparam int HTOTAL = HACTIVE + HFP + HSYNC + HBP;
   localparam int VTOTAL = VACTIVE + VFP + VSYNC + VBP;
   localparam int HS_LO  = HACTIVE + HFP;
   localparam int HS_HI  = HACTIVE + HFP + HSYNC;
   localparam int VS_LO  = VACTIVE + VFP;
   localparam int VS_HI  = VACTIVE + VFP + VSYNC;
   localparam int DW     = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [9:0]    H_LAST   = 10'(HTOTAL - 1);
   localparam logic [9:0]    V_LAST   = 10'(VTOTAL - 1);

   // The scan counters are 10 bits wide, so larger timings cannot be represented.
   generate
      if (HTOTAL > 1024 || VTOTAL > 1024 || DIV < 1) begin : g_bad_param
         $error("vga_timing_gen: illegal timing parameters");
      end
   endgenerate

   logic [DW-1:0] divcnt;
   logic [9:0]    hcnt;
   logic [9:0]    vcnt;
   logic          active;
   logic          hs;
   logic          vs;

   assign pix_en      = (divcnt == DIV_LAST);
   assign x           = hcnt;
   assign y           = vcnt;
   assign vga_sync_n  = 1'b0;
   assign frame_start = pix_en && (hcnt == 10'd0) && (vcnt == 10'd0);

   assign active = (int'(hcnt) < HACTIVE) && (int'(vcnt) < VACTIVE);
   assign hs     = (int'(hcnt) >= HS_LO) && (int'(hcnt) < HS_HI);
   assign vs     = (int'(vcnt) >= VS_LO) && (int'(vcnt) < VS_HI);

   always_ff @(posedge clk) begin
      if (reset) begin
         divcnt <= '0;
         hcnt   <= '0;
         vcnt   <= '0;
      end else begin
         divcnt <= pix_en ? '0 : divcnt + 1'b1;
         if (pix_en) begin
            if (hcnt == H_LAST) begin
               hcnt <= '0;
               vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
            end else begin
               hcnt <= hcnt + 10'd1;
            end
         end
      end
   end

   // Sync, blank and colour all register on the same tick so they stay aligned at the pins.
   always_ff @(posedge clk) begin
      if (reset) begin
         vga_hsync_n <= 1'b1;
         vga_vsync_n <= 1'b1;
         vga_blank_n <= 1'b0;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
      end else if (pix_en) begin
         vga_hsync_n <= ~hs;
         vga_vsync_n <= ~vs;
         vga_blank_n <= active;
         vga_r       <= active ? r_in : 8'd0;
         vga_g       <= active ? g_in : 8'd0;
         vga_b       <= active ? b_in : 8'd0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing, a short-frame variant for vsync/frame/reset,
// and a DIV=1 miniature for the tiny-frame wrap.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   // default instance
   logic [9:0] d_x, d_y;
   logic [7:0] d_r_in, d_g_in, d_b_in, d_r, d_g, d_b;
   logic d_pix_en, d_hsync_n, d_vsync_n, d_blank_n, d_sync_n, d_fs;
   assign d_r_in = d_x[7:0];
   assign d_g_in = 8'hA5;
   assign d_b_in = d_y[7:0];

   vga_timing_gen u_def (
      .clk(clk), .reset(reset), .x(d_x), .y(d_y),
      .r_in(d_r_in), .g_in(d_g_in), .b_in(d_b_in),
      .pix_en(d_pix_en), .vga_hsync_n(d_hsync_n), .vga_vsync_n(d_vsync_n),
      .vga_blank_n(d_blank_n), .vga_sync_n(d_sync_n),
      .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .frame_start(d_fs)
   );

   // short-frame instance: 800 x 15 lines, vsync on lines 10..11
   logic [9:0] m_x, m_y;
   logic [7:0] m_r_in, m_g_in, m_b_in, m_r, m_g, m_b;
   logic m_pix_en, m_hsync_n, m_vsync_n, m_blank_n, m_sync_n, m_fs;
   assign m_r_in = m_x[7:0];
   assign m_g_in = 8'h3C;
   assign m_b_in = m_y[7:0];

   vga_timing_gen #(.VACTIVE(8), .VFP(2), .VSYNC(2), .VBP(3)) u_med (
      .clk(clk), .reset(reset), .x(m_x), .y(m_y),
      .r_in(m_r_in), .g_in(m_g_in), .b_in(m_b_in),
      .pix_en(m_pix_en), .vga_hsync_n(m_hsync_n), .vga_vsync_n(m_vsync_n),
      .vga_blank_n(m_blank_n), .vga_sync_n(m_sync_n),
      .vga_r(m_r), .vga_g(m_g), .vga_b(m_b), .frame_start(m_fs)
   );

   // miniature instance: DIV=1, 20 x 10
   logic [9:0] s_x, s_y;
   logic [7:0] s_r_in, s_g_in, s_b_in, s_r, s_g, s_b;
   logic s_pix_en, s_hsync_n, s_vsync_n, s_blank_n, s_sync_n, s_fs;
   assign s_r_in = s_x[7:0];
   assign s_g_in = 8'h11;
   assign s_b_in = s_y[7:0];

   vga_timing_gen #(.DIV(1), .HACTIVE(10), .HFP(2), .HSYNC(4), .HBP(4),
                    .VACTIVE(5), .VFP(2), .VSYNC(1), .VBP(2)) u_small (
      .clk(clk), .reset(reset), .x(s_x), .y(s_y),
      .r_in(s_r_in), .g_in(s_g_in), .b_in(s_b_in),
      .pix_en(s_pix_en), .vga_hsync_n(s_hsync_n), .vga_vsync_n(s_vsync_n),
      .vga_blank_n(s_blank_n), .vga_sync_n(s_sync_n),
      .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .frame_start(s_fs)
   );

   // Hold reset for 3 clks, release on a falling edge and return there.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      nvec++; if (d_x !== 10'd0 || d_y !== 10'd0) begin nerr++; $display("FAIL reset_xy: got (%0d,%0d) expected (0,0)", d_x, d_y); end
      nvec++; if (d_hsync_n !== 1'b1 || d_vsync_n !== 1'b1) begin nerr++; $display("FAIL reset_sync: got hs_n=%b vs_n=%b expected 1 1", d_hsync_n, d_vsync_n); end
      nvec++; if (d_blank_n !== 1'b0) begin nerr++; $display("FAIL reset_blank: got %b expected 0", d_blank_n); end
      nvec++; if ({d_r, d_g, d_b} !== 24'd0) begin nerr++; $display("FAIL reset_rgb: got %h expected 000000", {d_r, d_g, d_b}); end
      nvec++; if (d_sync_n !== 1'b0) begin nerr++; $display("FAIL sync_n_const: got %b expected 0", d_sync_n); end
      nvec++; if (d_pix_en !== 1'b0) begin nerr++; $display("FAIL reset_pix_en: got %b expected 0", d_pix_en); end
   endtask

   // Two full lines at defaults: counters, prescaler, hsync shape and colour masking.
   task automatic test_default_line();
      int ex, ey, ticks, lowclks, nfalls, lastfall;
      logic ep, mhs, mbl, prev_hs;
      logic [7:0] mr, mg, mb;
      ex = 0; ey = 0; ticks = 0; lowclks = 0; nfalls = 0; lastfall = -1;
      ep = 1'b0; mhs = 1'b1; mbl = 1'b0; mr = 8'd0; mg = 8'd0; mb = 8'd0; prev_hs = 1'b1;
      do_reset();
      for (int c = 0; c < 3400; c++) begin
         nvec++; if (d_pix_en !== ep) begin nerr++; $display("FAIL pix_en c=%0d: got %b expected %b", c, d_pix_en, ep); end
         nvec++; if (d_x !== 10'(ex) || d_y !== 10'(ey)) begin nerr++; $display("FAIL xy c=%0d: got (%0d,%0d) expected (%0d,%0d)", c, d_x, d_y, ex, ey); end
         nvec++; if (d_hsync_n !== mhs || d_blank_n !== mbl || d_vsync_n !== 1'b1) begin nerr++; $display("FAIL sync_blank c=%0d: got hs_n=%b blank_n=%b vs_n=%b expected %b %b 1", c, d_hsync_n, d_blank_n, d_vsync_n, mhs, mbl); end
         nvec++; if (d_r !== mr || d_g !== mg || d_b !== mb) begin nerr++; $display("FAIL rgb c=%0d: got %h%h%h expected %h%h%h", c, d_r, d_g, d_b, mr, mg, mb); end
         if (d_x == 10'd101 && d_y == 10'd0) begin
            nvec++; if (d_r !== 8'd100 || d_g !== 8'hA5) begin nerr++; $display("FAIL colour_pass: got r=%0d g=%h expected r=100 g=a5", d_r, d_g); end
         end
         if (d_x == 10'd700) begin
            nvec++; if ({d_r, d_g, d_b} !== 24'd0 || d_blank_n !== 1'b0) begin nerr++; $display("FAIL colour_blanked: got rgb=%h blank_n=%b expected 000000 0", {d_r, d_g, d_b}, d_blank_n); end
         end
         if (prev_hs && !d_hsync_n) begin
            nvec++; if (d_x !== 10'd657) begin nerr++; $display("FAIL hsync_fall_x: got %0d expected 657", d_x); end
            if (lastfall >= 0) begin
               nvec++; if (ticks - lastfall != 800) begin nerr++; $display("FAIL hsync_period: got %0d expected 800", ticks - lastfall); end
            end
            lastfall = ticks; nfalls++; lowclks = 0;
         end
         if (!prev_hs && d_hsync_n) begin
            nvec++; if (lowclks != 192) begin nerr++; $display("FAIL hsync_width: got %0d clks expected 192", lowclks); end
         end
         if (!d_hsync_n) lowclks++;
         prev_hs = d_hsync_n;
         if (ep) begin
            mbl = (ex < 640) && (ey < 480);
            mhs = !((ex >= 656) && (ex < 752));
            mr = mbl ? 8'(ex) : 8'd0;
            mg = mbl ? 8'hA5 : 8'd0;
            mb = mbl ? 8'(ey) : 8'd0;
            ticks++;
            if (ex == 799) begin ex = 0; ey = ey + 1; end else ex = ex + 1;
         end
         ep = ~ep;
         @(negedge clk);
      end
      nvec++; if (nfalls != 2) begin nerr++; $display("FAIL hsync_falls: got %0d expected 2", nfalls); end
   endtask

   // Short-frame variant: vsync width/position and frame_start spacing.
   task automatic test_vsync_frame();
      int nfs, t0, t1, vlow;
      logic prev_fs, prev_vs;
      nfs = 0; t0 = -1; t1 = -1; vlow = 0; prev_fs = 1'b0; prev_vs = 1'b1;
      do_reset();
      for (int c = 0; c < 30000 && nfs < 2; c++) begin
         if (m_fs) begin
            nvec++; if (prev_fs) begin nerr++; $display("FAIL frame_start_width: got 2+ clks expected 1"); end
            if (nfs == 0) t0 = c; else t1 = c;
            nfs++;
         end
         if (prev_vs && !m_vsync_n) begin
            nvec++; if (m_x !== 10'd1 || m_y !== 10'd10) begin nerr++; $display("FAIL vsync_fall_pos: got (%0d,%0d) expected (1,10)", m_x, m_y); end
         end
         if (!prev_vs && m_vsync_n) begin
            nvec++; if (vlow != 3200) begin nerr++; $display("FAIL vsync_width: got %0d clks expected 3200", vlow); end
         end
         if (!m_vsync_n) vlow++;
         prev_fs = m_fs; prev_vs = m_vsync_n;
         @(negedge clk);
      end
      nvec++; if (t0 != 1) begin nerr++; $display("FAIL first_frame_start: got clk %0d expected 1", t0); end
      nvec++; if (t1 - t0 != 24000) begin nerr++; $display("FAIL frame_period: got %0d expected 24000", t1 - t0); end
   endtask

   // Reset at (300,5) mid-frame: immediate restart, no sync glitch, clean first pixel.
   task automatic test_midframe_reset();
      int waited, glitches;
      waited = 0; glitches = 0;
      while (!(m_x == 10'd300 && m_y == 10'd5) && waited < 20000) begin
         @(negedge clk);
         waited++;
      end
      nvec++; if (waited >= 20000) begin nerr++; $display("FAIL reach_300_5: timeout at (%0d,%0d) expected (300,5)", m_x, m_y); end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         if (m_hsync_n !== 1'b1 || m_vsync_n !== 1'b1) glitches++;
         if (i == 0) begin
            nvec++; if (m_x !== 10'd0 || m_y !== 10'd0) begin nerr++; $display("FAIL midreset_xy: got (%0d,%0d) expected (0,0)", m_x, m_y); end
            nvec++; if (m_blank_n !== 1'b0 || {m_r, m_g, m_b} !== 24'd0) begin nerr++; $display("FAIL midreset_out: got blank_n=%b rgb=%h expected 0 000000", m_blank_n, {m_r, m_g, m_b}); end
         end
      end
      @(negedge clk);
      reset = 1'b0;
      nvec++; if (m_pix_en !== 1'b0) begin nerr++; $display("FAIL release_pix_en0: got %b expected 0", m_pix_en); end
      @(negedge clk);
      nvec++; if (m_pix_en !== 1'b1 || m_x !== 10'd0 || m_y !== 10'd0) begin nerr++; $display("FAIL release_first_tick: got pe=%b (%0d,%0d) expected 1 (0,0)", m_pix_en, m_x, m_y); end
      @(negedge clk);
      nvec++; if (m_x !== 10'd1 || m_blank_n !== 1'b1 || m_r !== 8'd0 || m_g !== 8'h3C) begin nerr++; $display("FAIL release_first_pixel: got x=%0d blank_n=%b r=%0d g=%h expected 1 1 0 3c", m_x, m_blank_n, m_r, m_g); end
      for (int c = 0; c < 600; c++) begin
         if (m_hsync_n !== 1'b1 || m_vsync_n !== 1'b1) glitches++;
         @(negedge clk);
      end
      nvec++; if (glitches != 0) begin nerr++; $display("FAIL sync_glitch: got %0d low samples expected 0", glitches); end
   endtask

   // DIV=1 miniature: pix_en always high, (19,9)->(0,0) wrap, 200-clk frames.
   task automatic test_small_frame();
      int ex, ey, nfs, lastfs;
      logic efs;
      ex = 0; ey = 0; nfs = 0; lastfs = -1;
      do_reset();
      for (int c = 0; c < 450; c++) begin
         efs = (ex == 0) && (ey == 0);
         nvec++; if (s_pix_en !== 1'b1) begin nerr++; $display("FAIL small_pix_en c=%0d: got %b expected 1", c, s_pix_en); end
         nvec++; if (s_x !== 10'(ex) || s_y !== 10'(ey)) begin nerr++; $display("FAIL small_xy c=%0d: got (%0d,%0d) expected (%0d,%0d)", c, s_x, s_y, ex, ey); end
         nvec++; if (s_fs !== efs) begin nerr++; $display("FAIL small_frame_start c=%0d: got %b expected %b", c, s_fs, efs); end
         if (s_fs) begin
            if (lastfs >= 0) begin
               nvec++; if (c - lastfs != 200) begin nerr++; $display("FAIL small_period: got %0d expected 200", c - lastfs); end
            end
            lastfs = c; nfs++;
         end
         if (ex == 19) begin ex = 0; ey = (ey == 9) ? 0 : ey + 1; end else ex = ex + 1;
         @(negedge clk);
      end
      nvec++; if (nfs != 3) begin nerr++; $display("FAIL small_frames: got %0d expected 3", nfs); end
   endtask

   initial begin
      test_reset();
      test_default_line();
      test_vsync_frame();
      test_midframe_reset();
      test_small_frame();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at 2000000 expected finish earlier");
      $fatal(1, "watchdog expired");
   end

endmodule
